// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: forward AES SubBytes over a 128-bit state, time-multiplexed
// across LANES S-box instances (16/LANES cycles per block).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   state_in valid          in_ready   block idle, can accept
//   state_in   input state (byte k = bits [8k+7:8k])
//   out_valid  state_out holds result  out_ready  downstream accepts
//   state_out  substituted state (holds last result outside DONE)
//   blk_cnt    saturating count of output handshakes (SUB_BYTES_CNT_EN only)
//
// Optional feature macro: SUB_BYTES_CNT_EN adds the blk_cnt port and counter.
//
// state | meaning
// IDLE  | waiting for an input block, in_ready=1
// SUB   | substituting LANES bytes per cycle, group idx low bytes first
// DONE  | result presented on state_out, out_valid=1 until out_ready
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
`ifdef SUB_BYTES_CNT_EN
   ,
   output logic [15:0]  blk_cnt
`endif
);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
         $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam int         N    = 16 / LANES;
   localparam logic [3:0] LAST = 4'(N - 1);

   // Row-major FIPS-197 forward S-box; entry 0x00 sits in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
   endfunction

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t         state_q, state_d;
   logic [127:0]   work_q;
   logic [127:0]   work_sub;
   logic [127:0]   out_q;
   logic [3:0]     idx_q;
   logic           accept;
   logic           last_grp;

   assign accept   = (state_q == IDLE) && in_valid;
   assign last_grp = (idx_q == LAST);

   always_comb begin
      work_sub = work_q;
      for (int l = 0; l < LANES; l++) begin
         work_sub[(int'(idx_q) * LANES + l) * 8 +: 8] = sbox(work_q[(int'(idx_q) * LANES + l) * 8 +: 8]);
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SUB;
         end
         SUB: begin
            if (last_grp) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         out_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            work_q <= state_in;
            idx_q  <= '0;
         end else if (state_q == SUB) begin
            work_q <= work_sub;
            idx_q  <= last_grp ? 4'd0 : idx_q + 4'd1;
            if (last_grp) out_q <= work_sub;
         end
      end
   end

   assign state_out = out_q;

`ifdef SUB_BYTES_CNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_cnt_q <= '0;
      end else if (out_valid && out_ready && blk_cnt_q != 16'hFFFF) begin
         blk_cnt_q <= blk_cnt_q + 16'd1;
      end
   end

   assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: a LANES=4 instance for the main,
// backpressure and counter checks, plus LANES=1/2/8/16 instances fed in
// lock-step for the latency sweep and mid-operation reset.
module tb_sub_bytes_iter;

   localparam int LS[4] = '{1, 2, 8, 16};

   logic clk;
   int   cyc;
   int   total;
   int   bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // ---------------- main instance (LANES=4) ----------------
   logic         rst_a, valid_a, in_ready_a, out_valid_a, oready_a;
   logic [127:0] din_a, dout_a;
`ifdef SUB_BYTES_CNT_EN
   logic [15:0]  cnt_a;
`endif

   sub_bytes_iter #(.LANES(4)) dut_a (
      .clk(clk), .reset(rst_a), .in_valid(valid_a), .in_ready(in_ready_a),
      .state_in(din_a), .out_valid(out_valid_a), .out_ready(oready_a),
      .state_out(dout_a)
`ifdef SUB_BYTES_CNT_EN
      , .blk_cnt(cnt_a)
`endif
   );

   typedef struct {
      logic [127:0] exp;
      int           acc;
   } sb_t;
   sb_t q_a[$];

   initial begin : mon_a
      bit prev, hs;
      prev = 0;
      hs   = 0;
      forever begin
         @(negedge clk);
         if (!rst_a) begin
            q_a.delete();
            prev = 0;
            hs   = 0;
         end else begin
            if (hs) begin
               chk("a_in_ready_after_hs", in_ready_a, 1'b1);
               hs = 0;
            end
            if (out_valid_a && !prev) begin
               if (q_a.size() == 0) flag("a_spurious_out_valid");
               else chk("a_latency", cyc - q_a[0].acc, 4);
            end
            if (out_valid_a && oready_a && q_a.size() != 0) begin
               chk("a_data", dout_a, q_a[0].exp);
               void'(q_a.pop_front());
               hs = 1;
            end
            prev = out_valid_a;
         end
      end
   end

   // Leaves valid_a high; caller decides when to drop it.
   task automatic send_a(input logic [127:0] d, input logic [127:0] e);
      int n;
      sb_t s;
      din_a   = d;
      valid_a = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready_a || n >= 200) break;
         n++;
      end
      if (n >= 200) flag("a_accept_timeout");
      @(posedge clk);
      #1;
      s.exp = e;
      s.acc = cyc;
      q_a.push_back(s);
   endtask

   task automatic drain_a();
      int n;
      n = 0;
      while (q_a.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q_a.size() != 0) flag("a_drain_timeout");
      @(posedge clk);
      #1;
   endtask

   // ---------------- sweep instances ----------------
   logic         rst_s, valid_s, oready_s;
   logic [127:0] din_s;
   logic [3:0]   in_ready_s, out_valid_s;
   logic [127:0] dout_s[4];
`ifdef SUB_BYTES_CNT_EN
   logic [15:0]  cnt_s[4];
`endif
   logic [127:0] exp_s[32];
   int           acc_s[32];
   int           wr_s;

   initial wr_s = 0;
   assign oready_s = 1'b1;

   for (genvar g = 0; g < 4; g++) begin : gen_s
      localparam int NL = 16 / LS[g];
      int rd;
      bit prev;

      sub_bytes_iter #(.LANES(LS[g])) u_dut (
         .clk(clk), .reset(rst_s), .in_valid(valid_s), .in_ready(in_ready_s[g]),
         .state_in(din_s), .out_valid(out_valid_s[g]), .out_ready(oready_s),
         .state_out(dout_s[g])
`ifdef SUB_BYTES_CNT_EN
         , .blk_cnt(cnt_s[g])
`endif
      );

      initial begin
         rd   = 0;
         prev = 0;
         forever begin
            @(negedge clk);
            if (!rst_s) begin
               rd   = wr_s;
               prev = 0;
            end else begin
               if (out_valid_s[g] && !prev) begin
                  if (rd == wr_s) begin
                     flag($sformatf("s%0d_spurious_out_valid", LS[g]));
                  end else begin
                     chk($sformatf("s%0d_latency", LS[g]), cyc - acc_s[rd], NL);
                     chk($sformatf("s%0d_data", LS[g]), dout_s[g], exp_s[rd]);
                     rd++;
                  end
               end
               prev = out_valid_s[g];
            end
         end
      end
   end

   // Waits for every sweep instance to be idle so all accept on the same edge.
   task automatic send_s(input logic [127:0] d, input logic [127:0] e);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (&in_ready_s || n >= 200) break;
         n++;
      end
      if (n >= 200) flag("s_accept_timeout");
      din_s   = d;
      valid_s = 1'b1;
      @(posedge clk);
      #1;
      exp_s[wr_s] = e;
      acc_s[wr_s] = cyc;
      wr_s++;
      valid_s = 1'b0;
   endtask

   task automatic drain_s();
      int n;
      n = 0;
      while (!(gen_s[0].rd == wr_s && gen_s[1].rd == wr_s && gen_s[2].rd == wr_s &&
               gen_s[3].rd == wr_s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) flag("s_drain_timeout");
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] V_ORDER = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] E_ORDER = 128'h76abd7fe2b670130c56f6bf27b777c63;

   initial begin : stim
      logic [127:0] ex, ey;
      int n;
      total = 0;
      bad   = 0;
      rst_a = 1'b0; valid_a = 1'b0; din_a = '0; oready_a = 1'b1;
      rst_s = 1'b0; valid_s = 1'b0; din_s = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready_a, 1'b1);
      chk("rst_out_valid", out_valid_a, 1'b0);
      chk("rst_state_out", dout_a, '0);
      chk("rst_s16_state_out", dout_s[3], '0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      rst_s = 1'b1;

      // All-zero block and byte ordering
      send_a('0, {16{8'h63}});
      valid_a = 1'b0;
      drain_a();
      send_a(V_ORDER, E_ORDER);
      valid_a = 1'b0;
      drain_a();

      // Backpressure: 10-cycle stall with a second block already offered
      ex = {16{8'h7c}};
      ey = {16{8'h16}};
      oready_a = 1'b0;
      send_a({16{8'h01}}, ex);
      din_a = {16{8'hff}};
      n = 0;
      forever begin
         @(negedge clk);
         if (out_valid_a || n >= 50) break;
         n++;
      end
      if (n >= 50) flag("a_stall_wait_timeout");
      for (int i = 0; i < 10; i++) begin
         if (i != 0) @(negedge clk);
         chk("stall_out_valid", out_valid_a, 1'b1);
         chk("stall_in_ready", in_ready_a, 1'b0);
         chk("stall_state_out", dout_a, ex);
      end
      @(posedge clk);
      #1;
      oready_a = 1'b1;
      send_a({16{8'hff}}, ey);
      valid_a = 1'b0;
      drain_a();

      // LANES sweep
      send_s({16{8'hff}}, {16{8'h16}});
      drain_s();
      send_s({16{8'h53}}, {16{8'hed}});
      drain_s();

      // Reset two cycles into a LANES=1 block
      send_s({16{8'h53}}, {16{8'hed}});
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_s = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid_s[0], 1'b0);
      chk("mid_rst_in_ready", in_ready_s[0], 1'b1);
      chk("mid_rst_state_out", dout_s[0], '0);
      repeat (2) @(posedge clk);
      #1;
      rst_s = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      send_s(V_ORDER, E_ORDER);
      drain_s();

`ifdef SUB_BYTES_CNT_EN
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) oready_a = 1'b0;
         send_a('0, {16{8'h63}});
         valid_a = 1'b0;
         if (i == 2) begin
            repeat (7) @(posedge clk);
            #1;
            oready_a = 1'b1;
         end
         drain_a();
      end
      chk("cnt_five", cnt_a, 16'd5);
      rst_a = 1'b0;
      #1;
      chk("cnt_after_reset", cnt_a, 16'd0);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      force dut_a.blk_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut_a.blk_cnt_q;
      send_a('0, {16{8'h63}});
      valid_a = 1'b0;
      drain_a();
      chk("cnt_saturated", cnt_a, 16'hFFFF);
`endif

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Forward AES SubBytes unit for the encryption datapath; the counterpart of the decryption-side inverse S-box stage.
- Substitutes all 16 bytes of a 128-bit state through the FIPS-197 forward S-box.
- Uses a reduced number of S-box instances, time-multiplexed over several cycles, to save area.
- Sits between the AddRoundKey and ShiftRows stages of an iterative encryption round controller, with valid/ready handshakes on both sides.

Parameters:
- LANES, 4, S-box instances used in parallel. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration-time error.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a new state.
- state_in  input  128  input state; byte k = bits [8k+7:8k].
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts the result.
- state_out  output  128  substituted state; byte k = sbox(state_in byte k).
- blk_cnt  output  16  completed-block counter; present only with SUB_BYTES_CNT_EN.

Behaviour:
- Constants: N = 16/LANES processing cycles; a 4-bit byte-group index idx runs 0..N-1.
- States: IDLE, SUB, DONE.
- Reset (reset low, asynchronous): state=IDLE, in_ready=1, out_valid=0, state_out=0, idx=0, blk_cnt=0.
  - Reset asserted mid-SUB or mid-DONE aborts the block; the partial result is discarded and no output handshake occurs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a rising edge: capture state_in into an internal register, set idx=0, go to SUB.
- SUB:
  - in_ready=0.
  - Each cycle, replace bytes idx*LANES .. idx*LANES+LANES-1 of the internal register with their S-box values, then increment idx.
  - Bytes are processed low index first.
  - On the edge that processes idx=N-1: go to DONE and drive state_out from the completed register.
- DONE:
  - out_valid=1, in_ready=0.
  - state_out stays stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready at an edge: out_valid=0, go to IDLE.
- Latency: out_valid rises exactly N rising edges after the accept edge (LANES=16: 1 edge; LANES=1: 16 edges).
- Throughput: with out_ready held high, one block per N+2 cycles. No accept in the same cycle as an output handshake.
- state_out outside DONE: holds the last result (0 after reset). Not qualified without out_valid.
- S-box: combinational forward table, 256 entries, per FIPS-197 (e.g. 00->63, 01->7C, 53->ED, FF->16).
- No X propagation: in_valid while busy is ignored, and state_in is not sampled.
- Inputs are assumed synchronous to clk.

Optional Feature:
- Macro: SUB_BYTES_CNT_EN.
- Defined:
  - Adds output port blk_cnt[15:0], incremented by 1 on each output handshake (out_valid&&out_ready).
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset.
- Undefined: the port and counter logic do not exist. All other behaviour is identical.

Test Plan:
- All-zero block, LANES=4:
  - Stimulus: state_in=128'h0 accepted with out_ready=1.
  - Response: out_valid rises 4 edges later; state_out=128'h63636363636363636363636363636363; in_ready returns to 1 one cycle after the handshake.
- Byte-order check:
  - Stimulus: state_in=128'h0f0e0d0c0b0a09080706050403020100.
  - Response: state_out=128'h76abd7fe2b670130c56f6bf27b777c63.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, then 1; in_valid held high with a different state_in throughout.
  - Response: state_out stable and in_ready=0 during the stall; the second block is accepted only after returning to IDLE.
- LANES sweep (1, 2, 8, 16):
  - Stimulus: state_in=128'hFF...FF, then 128'h5353...53.
  - Response: latency 16/8/2/1 edges; outputs all 16 and all ED respectively.
- Reset mid-operation:
  - Stimulus: drive reset low 2 cycles after accept (LANES=1).
  - Response: out_valid=0 and in_ready=1 immediately (asynchronously); state_out=0; no spurious out_valid after release.
- SUB_BYTES_CNT_EN:
  - Stimulus: 5 blocks completed with one 3-cycle stall; reset; then force blk_cnt to FFFF and complete one block.
  - Response: blk_cnt=5 before reset, 0 after reset, and remains FFFF after the extra block (saturated).
